// File: rtl/program_sequencer.sv
// Fetches each instruction (plus the mvi immediate) from 1-cycle memory, drives din, pulses run, waits for done.
// start->run 3 cycles (5 for mvi), done->run 4 (6); holds in WAIT/PAUSE, watchdog aborts after TIMEOUT cycles.
module program_sequencer #(
  parameter int AW      = 5,
  parameter int DW      = 9,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          step_mode,
  input  logic          step,
  input  logic          halt,
  input  logic [AW-1:0] end_addr,
  output logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_data,
  output logic [DW-1:0] din,
  output logic          run,
  input  logic          done,
  output logic          busy,
  output logic [AW-1:0] pc,
  output logic          finished,
  output logic          err_timeout
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] WD_MAX = CW'(TIMEOUT);
  localparam logic [2:0] OP_MVI = 3'b001;

  typedef enum logic [3:0] {
    IDLE, FETCH_I, LATCH_I, FETCH_D, LATCH_D, ISSUE, IMM, WAIT, ADVANCE, PAUSE
  } state_t;

  state_t        state, state_n;
  logic [DW-1:0] ir_buf, imm_buf, din_q;
  logic [CW-1:0] wd_cnt;
  logic          halt_pend;
  logic [AW-1:0] pc_n, last_addr;
  logic          finished_n, err_n;
  logic          is_mvi, stop_req;

  assign is_mvi    = (ir_buf[DW-1:DW-3] == OP_MVI);
  assign stop_req  = halt | halt_pend;
  // the immediate slot counts as part of an mvi for the end-of-program test
  assign last_addr = is_mvi ? pc + AW'(1) : pc;
  assign busy      = (state != IDLE);

  always_comb begin
    state_n    = state;
    pc_n       = pc;
    finished_n = finished;
    err_n      = err_timeout;
    mem_addr   = pc;
    din        = din_q;
    run        = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          pc_n       = '0;
          finished_n = 1'b0;
          err_n      = 1'b0;
          state_n    = FETCH_I;
        end
      end
      FETCH_I: state_n = LATCH_I;
      LATCH_I: state_n = (mem_data[DW-1:DW-3] == OP_MVI) ? FETCH_D : ISSUE;
      FETCH_D: begin
        mem_addr = pc + AW'(1);
        state_n  = LATCH_D;
      end
      LATCH_D: state_n = ISSUE;
      ISSUE: begin
        din     = ir_buf;
        run     = 1'b1;
        state_n = is_mvi ? IMM : WAIT;
      end
      IMM: begin
        din     = imm_buf;
        state_n = WAIT;
      end
      WAIT: begin
        if (done) begin
          state_n = ADVANCE;
        end else if (wd_cnt == WD_MAX) begin
          err_n   = 1'b1;
          state_n = IDLE;
        end
      end
      ADVANCE: begin
        pc_n = is_mvi ? pc + AW'(2) : pc + AW'(1);
        if (stop_req || (last_addr >= end_addr)) begin
          finished_n = 1'b1;
          state_n    = IDLE;
        end else if (step_mode) begin
          state_n = PAUSE;
        end else begin
          state_n = FETCH_I;
        end
      end
      PAUSE: begin
        if (stop_req) begin
          finished_n = 1'b1;
          state_n    = IDLE;
        end else if (step) begin
          state_n = FETCH_I;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= '0;
      finished    <= 1'b0;
      err_timeout <= 1'b0;
      ir_buf      <= '0;
      imm_buf     <= '0;
      din_q       <= '0;
      wd_cnt      <= '0;
      halt_pend   <= 1'b0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      finished    <= finished_n;
      err_timeout <= err_n;
      din_q       <= din;
      if (state == LATCH_I) ir_buf <= mem_data;
      if (state == LATCH_D) imm_buf <= mem_data;
      // wd_cnt reads as the number of cycles since ISSUE (0 during ISSUE itself)
      if (state_n == ISSUE) wd_cnt <= '0;
      else if (wd_cnt != WD_MAX) wd_cnt <= wd_cnt + CW'(1);
      if (state_n == IDLE) halt_pend <= 1'b0;
      else if (halt && state != IDLE) halt_pend <= 1'b1;
    end
  end

endmodule

// File: tb/tb_program_sequencer.sv
// Randomized bench for program_sequencer: a program-level reference model fills a scoreboard that a run monitor drains.
module tb_program_sequencer;

  logic       clk = 1'b0;
  logic       rst, start, step_mode, step, halt, done;
  logic [4:0] end_addr, mem_addr, pc;
  logic [8:0] mem_data, din;
  logic       run, busy, finished, err_timeout;

  program_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .step_mode(step_mode), .step(step), .halt(halt),
    .end_addr(end_addr), .mem_addr(mem_addr), .mem_data(mem_data), .din(din), .run(run),
    .done(done), .busy(busy), .pc(pc), .finished(finished), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [8:0] ir;
    logic [8:0] imm;
    bit         mvi;
    int         pc;
    int         lat;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  logic [8:0] mem[32];
  logic [4:0] ah[4];
  logic [8:0] imm_val;
  bit         imm_due = 0;
  bit         done_en = 1;
  bit         auto_step = 0;
  int         dd_fixed = 2;
  int         vectors = 0;
  int         miscompares = 0;
  int         cyc = 0;
  int         trig = 0;
  int         run_cnt = 0;
  int         exp_pc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) mem_data <= mem[mem_addr];

  // Monitor: pops one expected instruction per run pulse.
  always @(negedge clk) begin
    if (imm_due) begin
      chk("imm_din", din, imm_val);
      imm_due = 0;
    end
    if (run) begin
      run_cnt++;
      chk("run_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        chk("run_din", din, mon_e.ir);
        chk("run_latency", cyc - trig, mon_e.lat);
        chk("fetch_addr", mon_e.mvi ? ah[3] : ah[1], mon_e.pc);
        if (mon_e.mvi) begin
          chk("imm_addr", ah[1], (mon_e.pc + 1) % 32);
          imm_due = 1;
          imm_val = mon_e.imm;
        end
      end
    end
    if ((start && !busy) || done || step) trig = cyc;
    ah[3] = ah[2];
    ah[2] = ah[1];
    ah[1] = ah[0];
    ah[0] = mem_addr;
  end

  // Processor stand-in: answers each run with a done pulse a few cycles later.
  initial begin
    int d;
    forever begin
      @(negedge clk);
      if (run) begin
        d = (dd_fixed > 0) ? dd_fixed : $urandom_range(2, 4);
        repeat (d) @(posedge clk);
        #1 if (done_en) done = 1'b1;
        @(posedge clk);
        #1 done = 1'b0;
      end
    end
  end

  // Operator stand-in for single-step mode.
  initial begin
    forever begin
      @(negedge clk);
      if (done && auto_step) begin
        repeat (5) @(posedge clk);
        #1 if (busy) step = 1'b1;
        @(posedge clk);
        #1 step = 1'b0;
      end
    end
  end

  // Reference model: walk the program as the processor would see it.
  task automatic build(input int limit, input bit sm);
    int   p, n, last;
    bit   m;
    exp_t e;
    p = 0;
    n = 0;
    while (n < limit) begin
      m     = (mem[p][8:6] == 3'b001);
      e.ir  = mem[p];
      e.imm = mem[(p + 1) % 32];
      e.mvi = m;
      e.pc  = p;
      e.lat = ((n == 0 || sm) ? 3 : 4) + (m ? 2 : 0);
      exp_q.push_back(e);
      last = m ? (p + 1) % 32 : p;
      p    = (p + (m ? 2 : 1)) % 32;
      n++;
      if (last >= int'(end_addr)) break;
    end
    exp_pc = p;
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_runs(input int target, input int bound);
    int k = 0;
    while (run_cnt < target && k < bound) begin
      @(posedge clk);
      k++;
    end
    chk("run_count_reached", run_cnt >= target, 1);
  endtask

  task automatic finish_prog();
    int k = 0;
    while (busy && k < 3000) begin
      @(negedge clk);
      k++;
    end
    repeat (8) @(negedge clk);
    chk("end_busy", busy, 0);
    chk("end_pc", pc, exp_pc);
    chk("end_finished", finished, 1);
    chk("end_err_timeout", err_timeout, 0);
    chk("end_queue_drained", exp_q.size(), 0);
  endtask

  task automatic run_prog(input int limit, input bit sm);
    step_mode = sm;
    build(limit, sm);
    pulse_start();
    finish_prog();
    step_mode = 1'b0;
  endtask

  task automatic rand_mem();
    logic [8:0] w;
    for (int i = 0; i < 32; i++) begin
      w = 9'($urandom);
      if ($urandom_range(0, 3) == 0) w[8:6] = 3'b001;
      else if (w[8:6] == 3'b001) w[8:6] = 3'b100;
      mem[i] = w;
    end
  endtask

  task automatic load_straight();
    mem[0] = 9'b000_001_010;
    mem[1] = 9'b010_000_001;
    mem[2] = 9'b011_001_000;
  endtask

  initial begin
    #800000;
    $display("FAIL global_timeout: bench still running at t=%0t", $time);
    $fatal(1, "bench stuck");
  end

  initial begin
    int base, k;
    rst = 1'b1; start = 1'b0; step_mode = 1'b0; step = 1'b0; halt = 1'b0; done = 1'b0;
    end_addr = '0;
    for (int i = 0; i < 32; i++) mem[i] = '0;
    for (int i = 0; i < 4; i++) ah[i] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {mem_addr, din, run, busy, pc, finished, err_timeout}, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // straight-line program, done two cycles after each run
    load_straight();
    end_addr = 5'd2;
    run_prog(64, 0);

    // mvi with its immediate
    mem[0] = 9'b001_000_000;
    mem[1] = 9'h0A5;
    end_addr = 5'd1;
    run_prog(64, 0);

    // single-step through three instructions
    load_straight();
    end_addr = 5'd2;
    auto_step = 1;
    run_prog(64, 1);
    auto_step = 0;

    // halt and step together while paused
    step_mode = 1'b1;
    build(1, 1);
    base = run_cnt;
    pulse_start();
    wait_runs(base + 1, 100);
    repeat (6) @(posedge clk);
    #1 halt = 1'b1; step = 1'b1;
    @(posedge clk);
    #1 halt = 1'b0; step = 1'b0;
    finish_prog();
    step_mode = 1'b0;

    // watchdog: done never arrives
    mem[0] = 9'b010_001_010;
    end_addr = 5'd0;
    done_en = 0;
    build(1, 0);
    base = run_cnt;
    pulse_start();
    wait_runs(base + 1, 50);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!err_timeout && k < 40);
    chk("timeout_cycles", k, 16);
    chk("timeout_err", err_timeout, 1);
    chk("timeout_busy", busy, 0);
    chk("timeout_finished", finished, 0);
    done_en = 1;
    repeat (4) @(negedge clk);

    // random programs, free-running
    dd_fixed = 0;
    for (int it = 0; it < 6; it++) begin
      rand_mem();
      end_addr = 5'($urandom_range(0, 12));
      run_prog(64, 0);
    end

    // random programs, single-step
    auto_step = 1;
    for (int it = 0; it < 3; it++) begin
      rand_mem();
      end_addr = 5'($urandom_range(0, 6));
      run_prog(64, 1);
    end
    auto_step = 0;

    // halt raised during an instruction is honoured at its completion
    for (int it = 0; it < 3; it++) begin
      rand_mem();
      end_addr = 5'd31;
      k = $urandom_range(1, 4);
      build(k, 0);
      base = run_cnt;
      pulse_start();
      wait_runs(base + k, 200);
      #1 halt = 1'b1;
      @(posedge clk);
      #1 halt = 1'b0;
      finish_prog();
    end

    // mvi at the top address wraps its immediate fetch, then reset in WAIT
    dd_fixed = 2;
    rand_mem();
    for (int i = 0; i < 31; i++) if (mem[i][8:6] == 3'b001) mem[i][8:6] = 3'b011;
    mem[0]  = 9'h0A5;
    mem[31] = 9'b001_011_000;
    end_addr = 5'd31;
    build(40, 0);
    base = run_cnt;
    pulse_start();
    wait_runs(base + 32, 1500);
    done_en = 0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrun_reset_outputs", {mem_addr, din, run, busy, pc, finished, err_timeout}, 0);
    exp_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    done_en = 1;
    base = run_cnt;
    repeat (20) @(negedge clk);
    chk("no_run_after_reset", run_cnt, base);
    chk("idle_after_reset", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
